// File: rtl/store_op_packer_if.sv
// Handshake bundle between the store-operand lanes, the launcher and the VLSU write channel.
// Signal names match the original flat port list of store_op_packer.
interface store_op_packer_if #(
  parameter int unsigned NrLanes   = 4,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned CntWidth  = 16,
  parameter int unsigned IdWidth   = 3
);
  localparam int unsigned BeatBytes = NrLanes * DataWidth / 8;

  logic                           req_valid_i;
  logic                           req_ready_o;
  logic [CntWidth-1:0]            req_bytes_i;
  logic [IdWidth-1:0]             req_id_i;
  logic [NrLanes-1:0]             lane_op_valid_i;
  logic [NrLanes-1:0]             lane_op_ready_o;
  logic [NrLanes*DataWidth-1:0]   lane_op_i;
  logic                           mem_w_valid_o;
  logic                           mem_w_ready_i;
  logic [NrLanes*DataWidth-1:0]   mem_w_data_o;
  logic [BeatBytes-1:0]           mem_w_strb_o;
  logic                           mem_w_last_o;
  logic                           done_valid_o;
  logic [IdWidth-1:0]             done_id_o;
  logic                           done_gnt_i;

  modport slave (
    input  req_valid_i, req_bytes_i, req_id_i, lane_op_valid_i, lane_op_i,
           mem_w_ready_i, done_gnt_i,
    output req_ready_o, lane_op_ready_o, mem_w_valid_o, mem_w_data_o,
           mem_w_strb_o, mem_w_last_o, done_valid_o, done_id_o
  );

  modport master (
    output req_valid_i, req_bytes_i, req_id_i, lane_op_valid_i, lane_op_i,
           mem_w_ready_i, done_gnt_i,
    input  req_ready_o, lane_op_ready_o, mem_w_valid_o, mem_w_data_o,
           mem_w_strb_o, mem_w_last_o, done_valid_o, done_id_o
  );
endinterface

// File: rtl/store_op_packer.sv
// Packs one operand word per lane into byte-strobed write beats, buffers them, and reports completion.
// Optional STORE_OP_PACKER_BYPASS_EN lets a beat skip an empty FIFO when memory is ready.
module store_op_packer #(
  parameter int unsigned NrLanes   = 4,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned FifoDepth = 4,
  parameter int unsigned CntWidth  = 16,
  parameter int unsigned IdWidth   = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  store_op_packer_if.slave   bus
);
  localparam int unsigned BeatBytes = NrLanes * DataWidth / 8;
  localparam int unsigned BeatW     = NrLanes * DataWidth;
  localparam int unsigned PtrW      = $clog2(FifoDepth);

  localparam logic [CntWidth-1:0] BeatBytesC = CntWidth'(BeatBytes);
  localparam logic [PtrW:0]       FullCnt    = (PtrW+1)'(FifoDepth);
  localparam logic [PtrW:0]       CntOne     = (PtrW+1)'(1);
  localparam logic [PtrW-1:0]     PtrOne     = PtrW'(1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_e;

  state_e              state_q;
  logic [CntWidth-1:0] rem_q;
  logic [IdWidth-1:0]  id_q;

  logic [BeatW-1:0]     fifo_data_q [FifoDepth];
  logic [BeatBytes-1:0] fifo_strb_q [FifoDepth];
  logic [FifoDepth-1:0] fifo_last_q;
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]        cnt_q;

  logic                 fifo_empty, fifo_full, all_valid, bypass;
  logic                 fire, push, pop, beat_last;
  logic [BeatBytes-1:0] beat_strb;
  logic [CntWidth-1:0]  beat_bytes;

  always_comb begin
    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == FullCnt);
    all_valid  = &bus.lane_op_valid_i;
    beat_last  = (rem_q <= BeatBytesC);
    beat_bytes = beat_last ? rem_q : BeatBytesC;
    beat_strb  = '0;
    for (int unsigned k = 0; k < BeatBytes; k++) begin
      beat_strb[k] = (CntWidth'(k) < rem_q);
    end
  end

`ifdef STORE_OP_PACKER_BYPASS_EN
  assign bypass = (state_q == ACTIVE) && fifo_empty && bus.mem_w_ready_i;
`else
  assign bypass = 1'b0;
`endif

  // Full FIFO blocks the lanes even if the head drains this cycle.
  assign fire = (state_q == ACTIVE) && all_valid && (!fifo_full || bypass);
  assign push = fire && !bypass;
  assign pop  = !fifo_empty && bus.mem_w_ready_i;

  assign bus.lane_op_ready_o = {NrLanes{fire}};
  assign bus.req_ready_o     = (state_q == IDLE);
  assign bus.done_valid_o    = (state_q == DONE);
  assign bus.done_id_o       = id_q;

  assign bus.mem_w_valid_o = !fifo_empty || (bypass && fire);
  assign bus.mem_w_data_o  = bypass ? bus.lane_op_i : fifo_data_q[rd_ptr_q];
  assign bus.mem_w_strb_o  = bypass ? beat_strb     : fifo_strb_q[rd_ptr_q];
  assign bus.mem_w_last_o  = bypass ? beat_last     : fifo_last_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      id_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.req_valid_i) begin
          rem_q   <= bus.req_bytes_i;
          id_q    <= bus.req_id_i;
          state_q <= (bus.req_bytes_i == '0) ? DONE : ACTIVE;
        end
        ACTIVE: if (fire) begin
          rem_q <= rem_q - beat_bytes;
          // A bypassed final beat is already accepted, so DRAIN has nothing to wait for.
          if (beat_last) state_q <= bypass ? DONE : DRAIN;
        end
        DRAIN: if (pop && fifo_last_q[rd_ptr_q]) state_q <= DONE;
        DONE:  if (bus.done_gnt_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      if (push && !pop)      cnt_q <= cnt_q + CntOne;
      else if (!push && pop) cnt_q <= cnt_q - CntOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= bus.lane_op_i;
      fifo_strb_q[wr_ptr_q] <= beat_strb;
      fifo_last_q[wr_ptr_q] <= beat_last;
    end
  end
endmodule

// File: tb/tb_store_op_packer.sv
// Directed bench for store_op_packer: beat packing, strobes, backpressure, lane skew, reset.
module tb_store_op_packer;
  localparam int unsigned NrLanes   = 4;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned FifoDepth = 4;
  localparam int unsigned CntWidth  = 16;
  localparam int unsigned IdWidth   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  store_op_packer_if #(.NrLanes(NrLanes), .DataWidth(DataWidth),
                       .CntWidth(CntWidth), .IdWidth(IdWidth)) bus ();

  store_op_packer #(.NrLanes(NrLanes), .DataWidth(DataWidth), .FifoDepth(FifoDepth),
                    .CntWidth(CntWidth), .IdWidth(IdWidth)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Lane i word for pop number k; each pop presents a fresh, distinguishable pattern.
  function automatic logic [255:0] beat_data(input int unsigned k);
    logic [255:0] d;
    for (int i = 0; i < 4; i++) d[i*64 +: 64] = {k[7:0], 8'(i), 48'h0123_4567_89AB};
    return d;
  endfunction

  logic [3:0]  lane_en = 4'h0;
  int unsigned pop_cnt = 0;

  always @(posedge clk) if (bus.lane_op_ready_o == 4'hF) pop_cnt <= pop_cnt + 1;
  always_comb bus.lane_op_valid_i = lane_en;
  always_comb bus.lane_op_i       = beat_data(pop_cnt);

  logic [255:0] cap_data [$];
  logic [31:0]  cap_strb [$];
  logic         cap_last [$];

  always @(negedge clk) begin
    if (!rst && bus.mem_w_valid_o && bus.mem_w_ready_i) begin
      cap_data.push_back(bus.mem_w_data_o);
      cap_strb.push_back(bus.mem_w_strb_o);
      cap_last.push_back(bus.mem_w_last_o);
    end
    if (bus.lane_op_ready_o != 4'h0) check("pop_all_or_none", bus.lane_op_ready_o, 4'hF);
  end

  task automatic send_req(input logic [15:0] bytes, input logic [2:0] id, output int unsigned base);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b1;
    bus.req_bytes_i = bytes;
    bus.req_id_i    = id;
    check("req_ready_idle", bus.req_ready_o, 1'b1);
    cap_data.delete(); cap_strb.delete(); cap_last.delete();
    base = pop_cnt;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    check("req_ready_busy", bus.req_ready_o, 1'b0);
  endtask

  task automatic wait_done(input logic [2:0] id, input int unsigned budget);
    int unsigned n = 0;
    while (!bus.done_valid_o && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_valid", bus.done_valid_o, 1'b1);
    check("done_id", bus.done_id_o, id);
    @(posedge clk); #1;
    check("done_held", bus.done_valid_o, 1'b1);
    bus.done_gnt_i = 1'b1;
    @(posedge clk); #1;
    bus.done_gnt_i = 1'b0;
    check("idle_after_gnt", bus.req_ready_o, 1'b1);
    check("done_cleared", bus.done_valid_o, 1'b0);
  endtask

  task automatic check_beats(input string tag, input int unsigned base, input int unsigned n,
                             input logic [31:0] last_strb);
    check({tag, "_beat_count"}, cap_data.size(), n);
    check({tag, "_pop_count"}, pop_cnt - base, n);
    for (int unsigned j = 0; j < n && j < cap_data.size(); j++) begin
      check($sformatf("%s_data%0d", tag, j), cap_data[j], beat_data(base + j));
      check($sformatf("%s_strb%0d", tag, j), cap_strb[j], (j == n-1) ? last_strb : 32'hFFFF_FFFF);
      check($sformatf("%s_last%0d", tag, j), cap_last[j], j == n-1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base;
    bus.req_valid_i   = 1'b0;
    bus.req_bytes_i   = '0;
    bus.req_id_i      = '0;
    bus.mem_w_ready_i = 1'b1;
    bus.done_gnt_i    = 1'b0;

    repeat (3) @(posedge clk); #1;
    check("rst_mem_valid", bus.mem_w_valid_o, 1'b0);
    check("rst_done_valid", bus.done_valid_o, 1'b0);
    check("rst_lane_ready", bus.lane_op_ready_o, 4'h0);
    check("rst_req_ready", bus.req_ready_o, 1'b1);
    rst = 1'b0;

    // 64 bytes: two full beats
    lane_en = 4'hF;
    send_req(16'd64, 3'd5, base);
    check("t1_fire", bus.lane_op_ready_o, 4'hF);
`ifndef STORE_OP_PACKER_BYPASS_EN
    check("t1_latency0", bus.mem_w_valid_o, 1'b0);
    @(posedge clk); #1;
    check("t1_latency1", bus.mem_w_valid_o, 1'b1);
`endif
    wait_done(3'd5, 20);
    check_beats("t1", base, 2, 32'hFFFF_FFFF);

    // 40 bytes: full beat then 8-byte tail
    send_req(16'd40, 3'd2, base);
    wait_done(3'd2, 20);
    check_beats("t2", base, 2, 32'h0000_00FF);

    // zero bytes: straight to done, no pops, no beats
    send_req(16'd0, 3'd7, base);
    check("t3_done_now", bus.done_valid_o, 1'b1);
    check("t3_no_pop", bus.lane_op_ready_o, 4'h0);
    check("t3_no_beat", bus.mem_w_valid_o, 1'b0);
    wait_done(3'd7, 2);
    check("t3_beat_count", cap_data.size(), 0);
    check("t3_pop_count", pop_cnt - base, 0);

    // 256 bytes with memory stalled for 10 cycles
    bus.mem_w_ready_i = 1'b0;
    send_req(16'd256, 3'd3, base);
    repeat (10) @(posedge clk); #1;
    check("t4_pops_while_full", pop_cnt - base, 4);
    check("t4_ready_low_full", bus.lane_op_ready_o, 4'h0);
    check("t4_mem_valid", bus.mem_w_valid_o, 1'b1);
    bus.mem_w_ready_i = 1'b1;
    wait_done(3'd3, 60);
    check_beats("t4", base, 8, 32'hFFFF_FFFF);

    // lane 2 late by three cycles
    lane_en = 4'b1011;
    send_req(16'd32, 3'd1, base);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("t5_wait%0d", c), bus.lane_op_ready_o, 4'h0);
      @(posedge clk); #1;
    end
    lane_en = 4'hF;
    #1;
    check("t5_all_pop", bus.lane_op_ready_o, 4'hF);
    wait_done(3'd1, 20);
    check_beats("t5", base, 1, 32'hFFFF_FFFF);

    // reset with one beat buffered
    bus.mem_w_ready_i = 1'b0;
    send_req(16'd128, 3'd4, base);
    @(posedge clk); #1;
    lane_en = 4'h0;
    check("t6_buffered", bus.mem_w_valid_o, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6_mem_valid", bus.mem_w_valid_o, 1'b0);
    check("t6_done_valid", bus.done_valid_o, 1'b0);
    check("t6_req_ready", bus.req_ready_o, 1'b1);
    repeat (3) @(posedge clk); #1;
    check("t6_no_done", bus.done_valid_o, 1'b0);
    bus.mem_w_ready_i = 1'b1;
    lane_en = 4'hF;
    send_req(16'd64, 3'd6, base);
    wait_done(3'd6, 20);
    check_beats("t6b", base, 2, 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
